digital_clock_ctrl: RTL



---
 rtl/digital_clock_ctrl_pkg.sv | 36 +++
 rtl/digital_clock_ctrl_if.sv | 25 ++
 rtl/digital_clock_ctrl_mod_counter.sv | 48 ++++
 rtl/digital_clock_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/digital_clock_ctrl_pkg.sv
// Shared definitions for the digital clock controller: mode encoding,
// default field moduli, derived field widths and the mode sequencing helper.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam int unsigned CSEC_MOD    = 100;
    localparam int unsigned SEC_MOD     = 60;
    localparam int unsigned MIN_MOD     = 60;
    localparam int unsigned HOUR_MOD    = 24;
    localparam int unsigned BLINK_TICKS = 50;

    localparam int unsigned CSEC_W = $clog2(CSEC_MOD);
    localparam int unsigned SEC_W  = $clog2(SEC_MOD);
    localparam int unsigned MIN_W  = $clog2(MIN_MOD);
    localparam int unsigned HOUR_W = $clog2(HOUR_MOD);

    // RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_RUN:      n = MODE_SET_HOUR;
            MODE_SET_HOUR: n = MODE_SET_MIN;
            MODE_SET_MIN:  n = MODE_SET_SEC;
            MODE_SET_SEC:  n = MODE_RUN;
            default:       n = MODE_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/digital_clock_ctrl_if.sv
// Bundle of the tick/button inputs and the time/mode/blink outputs of the
// clock controller. The controller uses the slave view.
interface digital_clock_ctrl_if;
    import clock_pkg::*;

    logic              i_tick;
    logic              i_btn_mode;
    logic              i_btn_inc;
    logic [HOUR_W-1:0] o_hour;
    logic [MIN_W-1:0]  o_min;
    logic [SEC_W-1:0]  o_sec;
    logic [CSEC_W-1:0] o_csec;
    logic [1:0]        o_mode;
    logic              o_blink;

    modport master (
        output i_tick, i_btn_mode, i_btn_inc,
        input  o_hour, o_min, o_sec, o_csec, o_mode, o_blink
    );

    modport slave (
        input  i_tick, i_btn_mode, i_btn_inc,
        output o_hour, o_min, o_sec, o_csec, o_mode, o_blink
    );
endinterface

// File: rtl/digital_clock_ctrl_mod_counter.sv
// Modulo-MOD counter with enable and synchronous clear. The carry is
// combinational so a chain of these can ripple a full cascade in one cycle.
module mod_counter #(
    parameter  int unsigned MOD = 10,
    localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_carry
);

    localparam logic [W-1:0] MAX_CNT = W'(MOD - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear wins, then wrap at MOD-1, otherwise step by one
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            if (cnt_q == MAX_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_carry = i_en && (cnt_q == MAX_CNT);

endmodule

// File: rtl/digital_clock_ctrl.sv
// Digital clock time-keeping controller: four chained modulo counters that
// advance on the 100 Hz tick in RUN, plus a mode FSM for setting hour,
// minute and second, and a blink strobe for the field being edited.
module digital_clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CSEC_MOD    = clock_pkg::CSEC_MOD,
    parameter int unsigned SEC_MOD     = clock_pkg::SEC_MOD,
    parameter int unsigned MIN_MOD     = clock_pkg::MIN_MOD,
    parameter int unsigned HOUR_MOD    = clock_pkg::HOUR_MOD,
    parameter int unsigned BLINK_TICKS = clock_pkg::BLINK_TICKS
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    digital_clock_ctrl_if.slave bus
);

    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

    mode_e              mode_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;

    logic csec_en_s, sec_en_s, min_en_s, hour_en_s, csec_clr_s;
    logic csec_carry_s, sec_carry_s, min_carry_s, hour_carry_s;
    logic run_s, edit_s;

    logic [$clog2(CSEC_MOD)-1:0] csec_s;
    logic [$clog2(SEC_MOD)-1:0]  sec_s;
    logic [$clog2(MIN_MOD)-1:0]  min_s;
    logic [$clog2(HOUR_MOD)-1:0] hour_s;

    // An inc only edits when no mode change happens on the same edge
    assign run_s  = (mode_q == MODE_RUN);
    assign edit_s = bus.i_btn_inc && !bus.i_btn_mode;

    // Counter enables: tick-driven cascade in RUN, single-field edit otherwise
    always_comb begin
        csec_en_s  = 1'b0;
        sec_en_s   = 1'b0;
        min_en_s   = 1'b0;
        hour_en_s  = 1'b0;
        csec_clr_s = (mode_q == MODE_SET_SEC) && bus.i_btn_mode;
        if (run_s) begin
            csec_en_s = bus.i_tick;
            sec_en_s  = csec_carry_s;
            min_en_s  = sec_carry_s;
            hour_en_s = min_carry_s;
        end else begin
            hour_en_s = edit_s && (mode_q == MODE_SET_HOUR);
            min_en_s  = edit_s && (mode_q == MODE_SET_MIN);
            sec_en_s  = edit_s && (mode_q == MODE_SET_SEC);
        end
    end

    mod_counter #(.MOD(CSEC_MOD)) u_csec (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(csec_en_s), .i_clr(csec_clr_s),
        .o_cnt(csec_s), .o_carry(csec_carry_s)
    );

    mod_counter #(.MOD(SEC_MOD)) u_sec (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(sec_en_s), .i_clr(1'b0),
        .o_cnt(sec_s), .o_carry(sec_carry_s)
    );

    mod_counter #(.MOD(MIN_MOD)) u_min (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(min_en_s), .i_clr(1'b0),
        .o_cnt(min_s), .o_carry(min_carry_s)
    );

    mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(hour_en_s), .i_clr(1'b0),
        .o_cnt(hour_s), .o_carry(hour_carry_s)
    );

    // Mode FSM with blink counter; mode changes and edits restart the blink
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q      <= MODE_RUN;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (bus.i_btn_mode) begin
            mode_q      <= next_mode(mode_q);
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (run_s || bus.i_btn_inc) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (bus.i_tick) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_q <= '0;
                blink_q     <= !blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    assign bus.o_csec  = csec_s;
    assign bus.o_sec   = sec_s;
    assign bus.o_min   = min_s;
    assign bus.o_hour  = hour_s;
    assign bus.o_mode  = mode_q;
    assign bus.o_blink = blink_q;

endmodule
